// File: rtl/calc1_port_driver.sv
// rtl/calc1_port_driver.sv - calc1 port stimulus driver: command FIFO, two-cycle request issue, paired response wait
//
// Ports:
//   c_clk, reset             clock (posedge) and synchronous active-high reset
//   stim_valid/stim_ready    command offer from the bench / FIFO not full
//   stim_cmd/op1/op2/last    command code, operands, end-of-test marker
//   req_cmd_in/req_data_in   request bus shared by the DUV and the reference model
//   duv_out_resp/ref_out_resp  response codes from DUV and reference (non-zero = responded)
//   test_change              level that inverts once per completed test
//   busy                     FIFO non-empty or a command in flight
//   timeout_err              sticky, a command was abandoned waiting for responses
//   issued_cnt               commands issued since reset, wrapping
module calc1_port_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 1
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        stim_valid,
    output logic        stim_ready,
    input  logic [0:3]  stim_cmd,
    input  logic [0:31] stim_op1,
    input  logic [0:31] stim_op2,
    input  logic        stim_last,
    output logic [0:3]  req_cmd_in,
    output logic [0:31] req_data_in,
    input  logic [0:1]  duv_out_resp,
    input  logic [0:1]  ref_out_resp,
    output logic        test_change,
    output logic        busy,
    output logic        timeout_err,
    output logic [0:15] issued_cnt
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_A   = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_MAX = (CNT_A > 4) ? CNT_A : 4;
    localparam int WCNT_W  = $clog2(CNT_MAX + 1);
    localparam int ENTRY_W = 4 + 32 + 32 + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_OP1,
        S_SEND_OP2,
        S_WAIT_RESP,
        S_GAP
    } state_t;

    state_t state, state_next;

    // FIFO entry layout: {cmd, op1, op2, last}
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     fifo_count;
    logic               fifo_full, fifo_empty;
    logic               push, pop;

    logic [0:3]         hold_cmd;
    logic [0:31]        hold_op1, hold_op2;
    logic               hold_last;

    logic               duv_seen, ref_seen;
    logic               duv_now, ref_now;
    logic [WCNT_W-1:0]  wait_cnt;
    logic               wait_done, wait_timeout, wait_exit;

    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign stim_ready = !fifo_full;
    assign push       = stim_valid && !fifo_full;
    assign busy       = (state != S_IDLE) || !fifo_empty;

    // Responses landing this cycle count towards completion immediately.
    assign duv_now = duv_seen || (duv_out_resp != 2'b00);
    assign ref_now = ref_seen || (ref_out_resp != 2'b00);

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        wait_done    = 1'b0;
        wait_timeout = 1'b0;
        wait_exit    = 1'b0;
        req_cmd_in   = '0;
        req_data_in  = '0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_SEND_OP1;
                end
            end
            S_SEND_OP1: begin
                req_cmd_in  = hold_cmd;
                req_data_in = hold_op1;
                state_next  = S_SEND_OP2;
            end
            S_SEND_OP2: begin
                req_data_in = hold_op2;
                state_next  = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                // A no-op gets no response, so it waits a fixed four cycles
                // to stay aligned with the bench.
                if (hold_cmd == 4'd0) begin
                    wait_done = (wait_cnt == WCNT_W'(3));
                end else begin
                    wait_done = duv_now && ref_now;
                end
                wait_timeout = !wait_done && (wait_cnt == WCNT_W'(TIMEOUT - 1));
                wait_exit    = wait_done || wait_timeout;
                if (wait_exit) begin
                    state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (wait_cnt == WCNT_W'(GAP_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {stim_cmd, stim_op1, stim_op2, stim_last};
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            hold_cmd    <= '0;
            hold_op1    <= '0;
            hold_op2    <= '0;
            hold_last   <= 1'b0;
            duv_seen    <= 1'b0;
            ref_seen    <= 1'b0;
            wait_cnt    <= '0;
            test_change <= 1'b0;
            timeout_err <= 1'b0;
            issued_cnt  <= '0;
        end else begin
            state <= state_next;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                hold_cmd  <= fifo_mem[rd_ptr][ENTRY_W-1 -: 4];
                hold_op1  <= fifo_mem[rd_ptr][ENTRY_W-5 -: 32];
                hold_op2  <= fifo_mem[rd_ptr][32:1];
                hold_last <= fifo_mem[rd_ptr][0];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                S_SEND_OP1: begin
                    issued_cnt <= issued_cnt + 16'd1;
                end
                S_SEND_OP2: begin
                    duv_seen <= 1'b0;
                    ref_seen <= 1'b0;
                    wait_cnt <= '0;
                end
                S_WAIT_RESP: begin
                    duv_seen <= duv_now;
                    ref_seen <= ref_now;
                    if (wait_exit) begin
                        // Counter is reused to time the inter-command gap.
                        wait_cnt <= '0;
                        if (wait_timeout) begin
                            timeout_err <= 1'b1;
                        end
                        if (hold_last) begin
                            test_change <= ~test_change;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                S_GAP: begin
                    wait_cnt <= wait_cnt + WCNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_driver.sv
// tb/tb_calc1_port_driver.sv - randomized self-checking bench for calc1_port_driver against a timeline model
module tb_calc1_port_driver;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 64;
    localparam int GAP_CYCLES = 1;
    localparam int MAXN       = 64;
    localparam int NEVER      = 999;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        stim_valid;
    logic        stim_ready;
    logic [0:3]  stim_cmd;
    logic [0:31] stim_op1;
    logic [0:31] stim_op2;
    logic        stim_last;
    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  duv_out_resp;
    logic [0:1]  ref_out_resp;
    logic        test_change;
    logic        busy;
    logic        timeout_err;
    logic [0:15] issued_cnt;

    calc1_port_driver #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .stim_valid   (stim_valid),
        .stim_ready   (stim_ready),
        .stim_cmd     (stim_cmd),
        .stim_op1     (stim_op1),
        .stim_op2     (stim_op2),
        .stim_last    (stim_last),
        .req_cmd_in   (req_cmd_in),
        .req_data_in  (req_data_in),
        .duv_out_resp (duv_out_resp),
        .ref_out_resp (ref_out_resp),
        .test_change  (test_change),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .issued_cnt   (issued_cnt)
    );

    always #5 c_clk = ~c_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_t    = 0;

    // Scenario: commands plus response delays (WAIT-cycle index) and push spacing.
    logic [3:0]  c_cmd  [MAXN];
    logic [31:0] c_op1  [MAXN];
    logic [31:0] c_op2  [MAXN];
    bit          c_last [MAXN];
    int          c_dd   [MAXN];
    int          c_dr   [MAXN];
    int          c_pgap [MAXN];
    // Timeline model: negedge indices, t=0 is the first negedge out of reset.
    int          t_push [MAXN];
    int          t_op1  [MAXN];
    int          t_exit [MAXN];
    bit          c_tmo  [MAXN];
    int          t_final;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0d got=0x%0h exp=0x%0h", tag, cur_t, got, exp);
    endtask

    task automatic set_cmd(input int i, input logic [3:0] cmd, input logic [31:0] op1,
                           input logic [31:0] op2, input bit last, input int dd, input int dr,
                           input int pgap);
        c_cmd[i]  = cmd;
        c_op1[i]  = op1;
        c_op2[i]  = op2;
        c_last[i] = last;
        c_dd[i]   = (cmd == 4'd0) ? NEVER : dd;
        c_dr[i]   = (cmd == 4'd0) ? NEVER : dr;
        c_pgap[i] = pgap;
    endtask

    task automatic compute_timeline(input int n);
        int idle_t, p, m, k;
        idle_t = 0;
        for (int i = 0; i < n; i++) begin
            p = (i == 0) ? c_pgap[i] : t_push[i-1] + 1 + c_pgap[i];
            if (i >= FIFO_DEPTH && t_op1[i-FIFO_DEPTH] > p) p = t_op1[i-FIFO_DEPTH];
            t_push[i] = p;
            t_op1[i]  = ((idle_t > p + 1) ? idle_t : p + 1) + 1;
            m = (c_cmd[i] == 4'd0) ? 3 : ((c_dd[i] > c_dr[i]) ? c_dd[i] : c_dr[i]);
            c_tmo[i]  = (m > TIMEOUT - 1);
            k = c_tmo[i] ? TIMEOUT - 1 : m;
            t_exit[i] = t_op1[i] + 3 + k;
            idle_t    = t_exit[i] + GAP_CYCLES;
        end
        t_final = idle_t;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        stim_valid   = 1'b0;
        stim_cmd     = '0;
        stim_op1     = '0;
        stim_op2     = '0;
        stim_last    = 1'b0;
        duv_out_resp = '0;
        ref_out_resp = '0;
        repeat (3) @(negedge c_clk);
        reset = 1'b0;
    endtask

    task automatic run_scenario(input int n, input bit rst_in_op2);
        int rst_at, t_end, exp_cnt, pi;
        logic [31:0] exp_cmd, exp_data, exp_iss;
        bit exp_tc, exp_tmo, exp_busy, in_wait;
        compute_timeline(n);
        rst_at = rst_in_op2 ? t_op1[0] + 1 : -1;
        t_end  = rst_in_op2 ? rst_at + 6 : t_final + 3;
        do_reset();
        for (int t = 0; t <= t_end; t++) begin
            cur_t = t;
            if (!rst_in_op2 || t <= rst_at) begin
                exp_cmd = 0; exp_data = 0; exp_iss = 0; exp_tc = 0; exp_tmo = 0;
                exp_cnt = 0; exp_busy = 0; in_wait = 0; pi = -1;
                for (int i = 0; i < n; i++) begin
                    if (t == t_op1[i]) begin
                        exp_cmd  = 32'(c_cmd[i]);
                        exp_data = c_op1[i];
                    end
                    if (t == t_op1[i] + 1) exp_data = c_op2[i];
                    if (t_op1[i] + 1 <= t) exp_iss++;
                    if (t_exit[i] <= t) begin
                        if (c_last[i]) exp_tc = ~exp_tc;
                        if (c_tmo[i]) exp_tmo = 1'b1;
                    end
                    if (t_push[i] < t) exp_cnt++;
                    if (t_op1[i] <= t) exp_cnt--;
                    if (t >= t_op1[i] && t < t_exit[i] + GAP_CYCLES) exp_busy = 1'b1;
                    if (t >= t_op1[i] + 2 && t < t_exit[i]) in_wait = 1'b1;
                    if (t == t_push[i]) pi = i;
                end
                if (exp_cnt > 0) exp_busy = 1'b1;
                check_eq("req_cmd_in", 32'(req_cmd_in), exp_cmd);
                check_eq("req_data_in", req_data_in, exp_data);
                check_eq("issued_cnt", 32'(issued_cnt), {16'd0, exp_iss[15:0]});
                check_eq("test_change", 32'(test_change), 32'(exp_tc));
                check_eq("timeout_err", 32'(timeout_err), 32'(exp_tmo));
                check_eq("busy", 32'(busy), 32'(exp_busy));
                check_eq("stim_ready", 32'(stim_ready), 32'(exp_cnt < FIFO_DEPTH));

                // Push schedule; while the model says full, offer junk that must be dropped.
                stim_cmd  = 4'($urandom);
                stim_op1  = $urandom;
                stim_op2  = $urandom;
                stim_last = 1'($urandom);
                if (pi >= 0) begin
                    stim_valid = 1'b1;
                    stim_cmd   = c_cmd[pi];
                    stim_op1   = c_op1[pi];
                    stim_op2   = c_op2[pi];
                    stim_last  = c_last[pi];
                end else begin
                    stim_valid = (exp_cnt >= FIFO_DEPTH);
                end

                duv_out_resp = '0;
                ref_out_resp = '0;
                for (int i = 0; i < n; i++) begin
                    if (c_dd[i] != NEVER && t == t_op1[i] + 2 + c_dd[i] && t < t_exit[i])
                        duv_out_resp = 2'($urandom_range(1, 3));
                    if (c_dr[i] != NEVER && t == t_op1[i] + 2 + c_dr[i] && t < t_exit[i])
                        ref_out_resp = 2'($urandom_range(1, 3));
                end
                if (!in_wait && $urandom_range(0, 3) == 0) duv_out_resp = 2'($urandom_range(1, 3));
                if (!in_wait && $urandom_range(0, 3) == 0) ref_out_resp = 2'($urandom_range(1, 3));

                if (t == rst_at) begin
                    reset        = 1'b1;
                    stim_valid   = 1'b0;
                    duv_out_resp = '0;
                    ref_out_resp = '0;
                end
            end else begin
                // Reset abandons the in-flight command and empties the FIFO.
                check_eq("rst_req_cmd_in", 32'(req_cmd_in), 32'd0);
                check_eq("rst_req_data_in", req_data_in, 32'd0);
                check_eq("rst_test_change", 32'(test_change), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd0);
                if (t == rst_at + 1) begin
                    check_eq("rst_issued_cnt", 32'(issued_cnt), 32'd0);
                    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
                    check_eq("rst_stim_ready", 32'(stim_ready), 32'd1);
                end
                reset      = 1'b0;
                stim_valid = 1'b0;
            end
            @(negedge c_clk);
        end
        stim_valid   = 1'b0;
        duv_out_resp = '0;
        ref_out_resp = '0;
    endtask

    initial begin
        int dd, dr;
        logic [3:0] rc;
        do_reset();

        // Single add, both sides respond at WAIT cycle 3.
        set_cmd(0, 4'd1, 32'h5, 32'h3, 1'b1, 3, 3, 0);
        run_scenario(1, 1'b0);

        // Staggered responses, then a follow-on command spaced by the gap.
        set_cmd(0, 4'd2, 32'h11, 32'h22, 1'b0, 2, 7, 0);
        set_cmd(1, 4'd3, 32'h33, 32'h44, 1'b1, 0, 0, 0);
        run_scenario(2, 1'b0);

        // Fill the FIFO behind a long-waiting command.
        set_cmd(0, 4'd4, 32'hA0, 32'hB0, 1'b0, 30, 30, 0);
        for (int i = 1; i < 6; i++)
            set_cmd(i, 4'(i + 1), 32'hA0 + 32'(i), 32'hB0 + 32'(i), (i == 5), 30, 28, (i == 1) ? 4 : 0);
        run_scenario(6, 1'b0);

        // No response: timeout, then a normal command with the flag held.
        set_cmd(0, 4'd6, 32'hDEAD, 32'hBEEF, 1'b1, NEVER, NEVER, 0);
        set_cmd(1, 4'd7, 32'h1234, 32'h5678, 1'b1, 2, 4, 0);
        run_scenario(2, 1'b0);

        // Two tests of two commands, including a no-op.
        set_cmd(0, 4'd8, 32'h1, 32'h2, 1'b0, 1, 1, 0);
        set_cmd(1, 4'd9, 32'h3, 32'h4, 1'b1, 0, 2, 0);
        set_cmd(2, 4'd0, 32'h5, 32'h6, 1'b0, 0, 0, 0);
        set_cmd(3, 4'd10, 32'h7, 32'h8, 1'b1, 5, 5, 0);
        run_scenario(4, 1'b0);

        // Reset while the first command is in SEND_OP2.
        for (int i = 0; i < 3; i++)
            set_cmd(i, 4'd12, 32'hC0 + 32'(i), 32'hD0 + 32'(i), 1'b1, 5, 5, 0);
        run_scenario(3, 1'b1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            rc = 4'($urandom_range(0, 15));
            dd = $urandom_range(0, 9);
            dr = $urandom_range(0, 9);
            if ($urandom_range(0, 19) == 0) dd = NEVER;
            set_cmd(i, rc, $urandom, $urandom, ($urandom_range(0, 3) == 0) || (i == 39),
                    dd, dr, $urandom_range(0, 6));
        end
        run_scenario(40, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
